game_session_ctl: RTL and testbench

Parametrised game-session controller that replaces the fixed single-round start/game/end sequencing and ammo/score bookkeeping in the game-control top level. It runs NUM_ROUNDS timed rounds, handles magazine/reserve ammo with partial reload, accumulates the player score and decides the winner. All drawing-layer enables and counters shown on screen come from this block.

---
 rtl/game_session_ctl.sv | 229 ++++++++++++++++++++++
 tb/tb_game_session_ctl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_session_ctl.sv
// Game-session controller: timed rounds, magazine/reserve ammo, score and winner.
// Optional macro STREAK_BONUS_EN: every third consecutive hit scores 2.
module game_session_ctl #(
   parameter int MAG_SIZE    = 3,
   parameter int TOTAL_AMMO  = 20,
   parameter int NUM_ROUNDS  = 3,
   parameter int ROUND_TICKS = 30,
   parameter int INTRO_TICKS = 2,
   parameter int SCORE_MAX   = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       left_mouse,
   input  logic       right_mouse,
   input  logic       start_hit,
   input  logic       target_hit,
   input  logic [6:0] enemy_score,
   output logic       start_screen_enable,
   output logic       game_enable,
   output logic       game_enable_posedge,
   output logic       game_end_enable,
   output logic       hunt_start,
   output logic [3:0] round_idx,
   output logic [6:0] round_time_left,
   output logic [2:0] bullets_in_magazine,
   output logic [6:0] bullets_left,
   output logic [6:0] my_score,
   output logic       show_reload_char,
   output logic       target_killed,
   output logic [1:0] winner_status,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INTRO     = 3'd1,
      S_PLAY      = 3'd2,
      S_ROUND_END = 3'd3,
      S_END       = 3'd4
   } state_e;

   localparam logic [2:0] MAG_FULL   = 3'(MAG_SIZE);
   localparam logic [6:0] RES_INIT   = 7'(TOTAL_AMMO - MAG_SIZE);
   localparam logic [6:0] ROUND_T    = 7'(ROUND_TICKS);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
   localparam logic [8:0] INTRO_T    = 9'(INTRO_TICKS);
   localparam logic [7:0] SCORE_M    = 8'(SCORE_MAX);

   state_e     state_q, state_d;
   logic       left_q, right_q;
   logic [7:0] intro_cnt_q, intro_cnt_d;
   logic [3:0] round_q, round_d;
   logic [6:0] time_q, time_d;
   logic [2:0] mag_q, mag_d;
   logic [6:0] res_q, res_d;
   logic [6:0] score_q, score_d;
   logic       posedge_q, posedge_d;
   logic       killed_q, killed_d;
   logic [1:0] winner_q, winner_d;
`ifdef STREAK_BONUS_EN
   logic [1:0] streak_q, streak_d;
`endif

   logic       shot, reload, out_of_ammo, enter_intro;
   logic [2:0] space, amt;
   logic [7:0] inc, sum;
   logic [6:0] score_hit;

   // Button events are the rising edge against a one-cycle-old sample.
   assign shot        = left_mouse & ~left_q;
   assign reload      = right_mouse & ~right_q;
   assign out_of_ammo = (mag_q == 3'd0) && (res_q == 7'd0);
   assign space       = MAG_FULL - mag_q;
   assign amt         = ({4'b0, space} < res_q) ? space : res_q[2:0];

`ifdef STREAK_BONUS_EN
   assign inc = (streak_q == 2'd2) ? 8'd2 : 8'd1;
`else
   assign inc = 8'd1;
`endif
   assign sum       = {1'b0, score_q} + inc;
   assign score_hit = (sum > SCORE_M) ? SCORE_M[6:0] : sum[6:0];

   always_comb begin
      state_d     = state_q;
      intro_cnt_d = intro_cnt_q;
      round_d     = round_q;
      time_d      = time_q;
      mag_d       = mag_q;
      res_d       = res_q;
      score_d     = score_q;
      winner_d    = winner_q;
      posedge_d   = 1'b0;
      killed_d    = 1'b0;
      enter_intro = 1'b0;
`ifdef STREAK_BONUS_EN
      streak_d    = streak_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (shot && start_hit) begin
               state_d     = S_INTRO;
               score_d     = 7'd0;
               round_d     = 4'd0;
               posedge_d   = 1'b1;
               enter_intro = 1'b1;
            end
         end
         S_INTRO: begin
            if (tick) begin
               if ({1'b0, intro_cnt_q} + 9'd1 >= INTRO_T) begin
                  state_d = S_PLAY;
                  time_d  = ROUND_T;
               end else begin
                  intro_cnt_d = intro_cnt_q + 8'd1;
               end
            end
         end
         S_PLAY: begin
            // The exit cycle swallows any tick, shot or reload arriving with it.
            if (time_q == 7'd0 || out_of_ammo) begin
               state_d = S_ROUND_END;
            end else begin
               if (tick) time_d = time_q - 7'd1;
               if (shot) begin
                  if (mag_q != 3'd0) begin
                     mag_d = mag_q - 3'd1;
                     if (target_hit) begin
                        score_d  = score_hit;
                        killed_d = 1'b1;
`ifdef STREAK_BONUS_EN
                        streak_d = (streak_q == 2'd2) ? 2'd0 : streak_q + 2'd1;
`endif
                     end else begin
`ifdef STREAK_BONUS_EN
                        streak_d = 2'd0;
`endif
                     end
                  end
               end else if (reload && amt != 3'd0) begin
                  mag_d = mag_q + amt;
                  res_d = res_q - {4'b0, amt};
               end
            end
         end
         S_ROUND_END: begin
            if (round_q < LAST_ROUND) begin
               state_d     = S_INTRO;
               round_d     = round_q + 4'd1;
               enter_intro = 1'b1;
            end else begin
               state_d = S_END;
               if (score_q > enemy_score)      winner_d = 2'b01;
               else if (score_q < enemy_score) winner_d = 2'b10;
               else                            winner_d = 2'b00;
            end
         end
         S_END: begin
            if (shot) begin
               state_d  = S_IDLE;
               winner_d = 2'b00;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_intro) begin
         mag_d       = MAG_FULL;
         res_d       = RES_INIT;
         intro_cnt_d = 8'd0;
`ifdef STREAK_BONUS_EN
         streak_d    = 2'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         intro_cnt_q <= 8'd0;
         round_q     <= 4'd0;
         time_q      <= 7'd0;
         mag_q       <= 3'd0;
         res_q       <= 7'd0;
         score_q     <= 7'd0;
         posedge_q   <= 1'b0;
         killed_q    <= 1'b0;
         winner_q    <= 2'b00;
`ifdef STREAK_BONUS_EN
         streak_q    <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         left_q      <= left_mouse;
         right_q     <= right_mouse;
         intro_cnt_q <= intro_cnt_d;
         round_q     <= round_d;
         time_q      <= time_d;
         mag_q       <= mag_d;
         res_q       <= res_d;
         score_q     <= score_d;
         posedge_q   <= posedge_d;
         killed_q    <= killed_d;
         winner_q    <= winner_d;
`ifdef STREAK_BONUS_EN
         streak_q    <= streak_d;
`endif
      end
   end

   assign start_screen_enable = (state_q == S_IDLE);
   assign game_enable         = (state_q == S_INTRO) || (state_q == S_PLAY) ||
                                (state_q == S_ROUND_END);
   assign game_end_enable     = (state_q == S_END);
   assign hunt_start          = (state_q == S_PLAY);
   assign game_enable_posedge = posedge_q;
   assign round_idx           = round_q;
   assign round_time_left     = time_q;
   assign bullets_in_magazine = mag_q;
   assign bullets_left        = res_q;
   assign my_score            = score_q;
   assign show_reload_char    = (state_q == S_PLAY) && (mag_q == 3'd0) && (res_q != 7'd0);
   assign target_killed       = killed_q;
   assign winner_status       = winner_q;
   assign state_dbg           = state_q;

endmodule

// File: tb/tb_game_session_ctl.sv
// Directed bench for game_session_ctl (NUM_ROUNDS=2) with a small ammo/score model.
module tb_game_session_ctl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       left_mouse = 1'b0;
   logic       right_mouse = 1'b0;
   logic       start_hit = 1'b0;
   logic       target_hit = 1'b0;
   logic [6:0] enemy_score = 7'd0;
   logic       start_screen_enable, game_enable, game_enable_posedge, game_end_enable;
   logic       hunt_start, show_reload_char, target_killed;
   logic [3:0] round_idx;
   logic [6:0] round_time_left, bullets_left, my_score;
   logic [2:0] bullets_in_magazine, state_dbg;
   logic [1:0] winner_status;

   int checks = 0;
   int failures = 0;
   int kill_cnt = 0;
   int kill_base;
   int exp_mag, exp_res, exp_score, exp_streak;

   game_session_ctl #(.NUM_ROUNDS(2)) dut (
      .clk(clk), .rst(rst), .tick(tick), .left_mouse(left_mouse),
      .right_mouse(right_mouse), .start_hit(start_hit), .target_hit(target_hit),
      .enemy_score(enemy_score), .start_screen_enable(start_screen_enable),
      .game_enable(game_enable), .game_enable_posedge(game_enable_posedge),
      .game_end_enable(game_end_enable), .hunt_start(hunt_start),
      .round_idx(round_idx), .round_time_left(round_time_left),
      .bullets_in_magazine(bullets_in_magazine), .bullets_left(bullets_left),
      .my_score(my_score), .show_reload_char(show_reload_char),
      .target_killed(target_killed), .winner_status(winner_status),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (target_killed === 1'b1) kill_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick = 1'b1; cyc(1);
         tick = 1'b0; cyc(1);
      end
   endtask

   task automatic intro_model();
      exp_mag = 3; exp_res = 17; exp_streak = 0;
   endtask

   task automatic add_hit();
`ifdef STREAK_BONUS_EN
      if (exp_streak == 2) begin exp_score += 2; exp_streak = 0; end
      else begin exp_score += 1; exp_streak++; end
`else
      exp_score += 1;
`endif
      if (exp_score > 99) exp_score = 99;
   endtask

   task automatic press_left();
      left_mouse = 1'b1; cyc(1);
      left_mouse = 1'b0; cyc(1);
   endtask

   task automatic fire(input logic hit, input string tag);
      int k;
      k = 0;
      left_mouse = 1'b1; target_hit = hit; cyc(1);
      if (exp_mag > 0) begin
         exp_mag--;
         if (hit) begin add_hit(); k = 1; end
         else exp_streak = 0;
      end
      check({tag, "_mag"}, bullets_in_magazine, exp_mag);
      check({tag, "_score"}, my_score, exp_score);
      check({tag, "_kill"}, target_killed, k);
      left_mouse = 1'b0; target_hit = 1'b0; cyc(1);
      check({tag, "_kill_end"}, target_killed, 0);
   endtask

   task automatic do_reload(input string tag);
      int amt;
      right_mouse = 1'b1; cyc(1);
      amt = (3 - exp_mag < exp_res) ? 3 - exp_mag : exp_res;
      exp_mag += amt; exp_res -= amt;
      check({tag, "_mag"}, bullets_in_magazine, exp_mag);
      check({tag, "_res"}, bullets_left, exp_res);
      right_mouse = 1'b0; cyc(1);
   endtask

   task automatic hits(input int n);
      repeat (n) begin
         if (exp_mag == 0) do_reload("hits_reload");
         fire(1'b1, "hits");
      end
   endtask

   task automatic start_game(input string tag);
      start_hit = 1'b1; left_mouse = 1'b1; cyc(1);
      intro_model(); exp_score = 0;
      check({tag, "_posedge"}, game_enable_posedge, 1);
      check({tag, "_game_en"}, game_enable, 1);
      check({tag, "_score"}, my_score, 0);
      check({tag, "_mag"}, bullets_in_magazine, 3);
      check({tag, "_res"}, bullets_left, 17);
      check({tag, "_round"}, round_idx, 0);
      left_mouse = 1'b0; cyc(1);
      check({tag, "_posedge_end"}, game_enable_posedge, 0);
   endtask

   task automatic expire_round();
      ticks(30);
      cyc(1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_start_scr"}, start_screen_enable, 1);
      check({tag, "_game_en"}, game_enable, 0);
      check({tag, "_posedge"}, game_enable_posedge, 0);
      check({tag, "_end_en"}, game_end_enable, 0);
      check({tag, "_hunt"}, hunt_start, 0);
      check({tag, "_round"}, round_idx, 0);
      check({tag, "_time"}, round_time_left, 0);
      check({tag, "_mag"}, bullets_in_magazine, 0);
      check({tag, "_res"}, bullets_left, 0);
      check({tag, "_score"}, my_score, 0);
      check({tag, "_reload_chr"}, show_reload_char, 0);
      check({tag, "_kill"}, target_killed, 0);
      check({tag, "_winner"}, winner_status, 0);
   endtask

   initial begin
      #1 rst = 1'b0;
      #7 check_reset("reset");
      #4 rst = 1'b1;
      cyc(2);

      // Shot outside the START button keeps the start screen.
      start_hit = 1'b0;
      press_left();
      check("idle_noshot", start_screen_enable, 1);

      // Session 1, round 0.
      start_game("start1");
      ticks(1);
      check("intro_tick1_hunt", hunt_start, 0);
      ticks(1);
      check("intro_done_hunt", hunt_start, 1);
      check("play_time", round_time_left, 30);

      kill_base = kill_cnt;
      repeat (4) fire(1'b1, "burst");
      check("burst_score", my_score, exp_score);
      check("burst_mag", bullets_in_magazine, 0);
      check("burst_reload_chr", show_reload_char, 1);
      check("burst_kills", kill_cnt - kill_base, 3);
      do_reload("reload1");
      check("reload1_chr", show_reload_char, 0);
      do_reload("reload_full");

      kill_base = kill_cnt;
      left_mouse = 1'b1; target_hit = 1'b1; cyc(50);
      exp_mag--; add_hit();
      left_mouse = 1'b0; target_hit = 1'b0; cyc(1);
      check("hold_mag", bullets_in_magazine, exp_mag);
      check("hold_score", my_score, exp_score);
      check("hold_kills", kill_cnt - kill_base, 1);

      left_mouse = 1'b1; right_mouse = 1'b1; cyc(1);
      exp_mag--; exp_streak = 0;
      check("both_mag", bullets_in_magazine, exp_mag);
      check("both_res", bullets_left, exp_res);
      left_mouse = 1'b0; right_mouse = 1'b0; cyc(1);

      while (exp_res > 2) begin
         while (exp_mag > 0) fire(1'b0, "burn");
         do_reload("burn_reload");
      end
      while (exp_mag > 0) fire(1'b0, "burn");
      check("low_res_chr", show_reload_char, 1);
      do_reload("partial");
      check("partial_chr", show_reload_char, 0);
      fire(1'b0, "drain");
      fire(1'b0, "drain");
      cyc(1);
      intro_model();
      check("r1_round", round_idx, 1);
      check("r1_game_en", game_enable, 1);
      check("r1_hunt", hunt_start, 0);
      check("r1_mag", bullets_in_magazine, 3);
      check("r1_res", bullets_left, 17);
      check("r1_score_kept", my_score, exp_score);

      // Session 1, round 1: tie at the end.
      ticks(2);
      hits(7);
      enemy_score = 7'(exp_score);
      ticks(29);
      check("r1_time_one", round_time_left, 1);
      ticks(1);
      check("r1_time_zero", round_time_left, 0);
      check("r1_exit_hunt", hunt_start, 0);
      cyc(1);
      check("end1_en", game_end_enable, 1);
      check("end1_game_en", game_enable, 0);
      check("end1_tie", winner_status, 2'b00);
      press_left();
      check("end1_to_idle", start_screen_enable, 1);

      // Session 2: win.
      start_game("start2");
      ticks(2);
      hits(12);
      enemy_score = 7'(exp_score - 1);
      expire_round();
      check("s2_round", round_idx, 1);
      ticks(2);
      expire_round();
      check("s2_end_en", game_end_enable, 1);
      check("s2_win", winner_status, 2'b01);
      press_left();

      // Session 3: loss with no shots.
      start_game("start3");
      enemy_score = 7'd1;
      ticks(2); expire_round();
      ticks(2); expire_round();
      check("s3_loss", winner_status, 2'b10);
      press_left();
      check("s3_to_idle", start_screen_enable, 1);

      // Session 4: asynchronous reset in the middle of PLAY.
      start_game("start4");
      ticks(2);
      hits(5);
      check("s4_mag", bullets_in_magazine, 1);
      check("s4_score", my_score, exp_score);
      #2 rst = 1'b0;
      #1 check_reset("midreset");
      #2 rst = 1'b1;
      cyc(3);
      check("post_reset_idle", start_screen_enable, 1);
      check("post_reset_game_en", game_enable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
